top: RTL and testbench

TOP -- requirements
Module: top

---
 rtl/top_pkg.sv | 18 +
 rtl/top.sv | 95 +++++++++
 tb/tb_top.sv | 111 +++++++++++
 3 files changed

// File: rtl/top_pkg.sv
// rtl/top_pkg.sv - shared state encoding, data width and default timing constants
package top_pkg;

   localparam int DATA_W          = 8;
   localparam int DEF_WAIT_CYCLES = 6;
   localparam int DEF_A_LIMIT     = 26;
   localparam int DEF_B_THRESH    = 4;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_INIT = 3'd1,
      ST_WAIT = 3'd2,
      ST_SETB = 3'd3,
      ST_LOOP = 3'd4,
      ST_DONE = 3'd5
   } state_t;

endpackage

// File: rtl/top.sv
// rtl/top.sv - counter sequencer: init, fixed wait, then a/b count loop ending in a one-cycle done pulse
module top
   import top_pkg::*;
#(
   parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
   parameter int A_LIMIT     = DEF_A_LIMIT,
   parameter int B_THRESH    = DEF_B_THRESH
) (
   input  logic              clk,
   input  logic              rst,
   output logic [DATA_W-1:0] a,
   output logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] c,
   output logic              d
);

   localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) + 1 : 1;
   localparam logic [CNT_W-1:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
   localparam logic [DATA_W-1:0] A_LIM = DATA_W'(A_LIMIT);
   localparam logic [DATA_W-1:0] B_THR = DATA_W'(B_THRESH);

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [DATA_W-1:0]  a_nxt, b_nxt, c_nxt;
   logic               d_nxt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= ST_INIT;
         cnt   <= '0;
         a     <= '0;
         b     <= '0;
         c     <= '0;
         d     <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         a     <= a_nxt;
         b     <= b_nxt;
         c     <= c_nxt;
         d     <= d_nxt;
      end
   end

   // Reset lands directly in INIT so its writes appear on the first edge after release.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      a_nxt     = a;
      b_nxt     = b;
      c_nxt     = c;
      d_nxt     = 1'b0;
      case (state)
         ST_IDLE: begin
            state_nxt = ST_INIT;
         end
         ST_INIT: begin
            a_nxt     = DATA_W'(1);
            b_nxt     = '0;
            c_nxt     = DATA_W'(1);
            cnt_nxt   = WAIT_LOAD;
            state_nxt = (WAIT_CYCLES > 0) ? ST_WAIT : ST_SETB;
         end
         ST_WAIT: begin
            if (cnt == '0) begin
               state_nxt = ST_SETB;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         ST_SETB: begin
            b_nxt     = DATA_W'(1);
            state_nxt = ST_LOOP;
         end
         ST_LOOP: begin
            if (a >= A_LIM) begin
               d_nxt     = 1'b1;
               state_nxt = ST_DONE;
            end else begin
               a_nxt = a + 1'b1;
               if (a >= B_THR) begin
                  b_nxt = b + 1'b1;
               end
            end
         end
         ST_DONE: begin
            state_nxt = ST_DONE;
         end
         default: begin
            state_nxt = ST_INIT;
         end
      endcase
   end

endmodule

// File: tb/tb_top.sv
// tb/tb_top.sv - directed self-checking bench for the counter sequencer
module tb_top;
   logic       clk;
   logic       rst;
   logic [7:0] a, b, c;
   logic       d;

   int checks;
   int failures;
   int cyc;
   int dpulses;

   top dut (
      .clk (clk),
      .rst (rst),
      .a   (a),
      .b   (b),
      .c   (c),
      .d   (d)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
      if (rst) cyc++;
      if (d === 1'b1) dpulses++;
   endtask

   task automatic advance_to(input int n);
      while (cyc < n) step();
   endtask

   task automatic expect_out(input string name, input logic [7:0] ea, input logic [7:0] eb,
                             input logic [7:0] ec, input logic ed);
      checks++;
      if ({a, b, c, d} !== {ea, eb, ec, ed}) begin
         failures++;
         $display("FAIL %s: got a=%0d b=%0d c=%0d d=%0b, want a=%0d b=%0d c=%0d d=%0b",
                  name, a, b, c, d, ea, eb, ec, ed);
      end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      dpulses = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         expect_out("reset_hold", 8'd0, 8'd0, 8'd0, 1'b0);
      end
      checks++;
      if (dpulses !== 0) begin
         failures++;
         $display("FAIL reset_no_pulse: got %0d d pulses, want 0", dpulses);
      end
      rst = 1'b1;
      cyc = 0;
   endtask

   task automatic test_sequence;
      dpulses = 0;
      advance_to(1);   expect_out("cycle1_init",  8'd1,  8'd0,  8'd1, 1'b0);
      advance_to(7);   expect_out("cycle7_wait",  8'd1,  8'd0,  8'd1, 1'b0);
      advance_to(8);   expect_out("cycle8_setb",  8'd1,  8'd1,  8'd1, 1'b0);
      advance_to(11);  expect_out("cycle11_below_thresh", 8'd4, 8'd1, 8'd1, 1'b0);
      advance_to(12);  expect_out("cycle12_at_thresh",    8'd5, 8'd2, 8'd1, 1'b0);
      advance_to(33);  expect_out("cycle33_limit", 8'd26, 8'd23, 8'd1, 1'b0);
      advance_to(34);  expect_out("cycle34_done",  8'd26, 8'd23, 8'd1, 1'b1);
      advance_to(35);  expect_out("cycle35_clear", 8'd26, 8'd23, 8'd1, 1'b0);
      advance_to(39);  expect_out("cycle39_hold",  8'd26, 8'd23, 8'd1, 1'b0);
      advance_to(139); expect_out("cycle139_hold", 8'd26, 8'd23, 8'd1, 1'b0);
      checks++;
      if (dpulses !== 1) begin
         failures++;
         $display("FAIL single_pulse: got %0d d pulses, want 1", dpulses);
      end
   endtask

   task automatic test_mid_reset;
      rst = 1'b0;
      step();
      rst = 1'b1;
      cyc = 0;
      advance_to(20);
      expect_out("loop_cycle20", 8'd13, 8'd10, 8'd1, 1'b0);
      rst = 1'b0;
      step();
      expect_out("mid_reset_zero", 8'd0, 8'd0, 8'd0, 1'b0);
      rst = 1'b1;
      cyc = 0;
      advance_to(7);  expect_out("restart_cycle7",  8'd1,  8'd0,  8'd1, 1'b0);
      advance_to(8);  expect_out("restart_cycle8",  8'd1,  8'd1,  8'd1, 1'b0);
      advance_to(39); expect_out("restart_cycle39", 8'd26, 8'd23, 8'd1, 1'b0);
   endtask

   initial begin
      checks = 0;
      failures = 0;
      cyc = 0;
      dpulses = 0;
      rst = 1'b0;
      test_reset();
      test_sequence();
      test_mid_reset();
      test_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
